// File: rtl/imem_loader_pkg.sv
// Shared encodings and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    // Frame layout: a two-byte big-endian word count precedes the data.
    localparam int HDR_BYTES = 2;
    // Running XOR over the data bytes is one byte wide.
    localparam int CSUM_W    = 8;

    localparam logic [2:0] ST_HDR_HI  = 3'd0;
    localparam logic [2:0] ST_HDR_LO  = 3'd1;
    localparam logic [2:0] ST_DATA_HI = 3'd2;
    localparam logic [2:0] ST_DATA_LO = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_RUN     = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;

    typedef enum logic [2:0] {
        S_HDR_HI  = ST_HDR_HI,
        S_HDR_LO  = ST_HDR_LO,
        S_DATA_HI = ST_DATA_HI,
        S_DATA_LO = ST_DATA_LO,
        S_CHECK   = ST_CHECK,
        S_RUN     = ST_RUN,
        S_ERR     = ST_ERR
    } state_t;

    // The loader takes bytes everywhere except the two terminal states.
    function automatic logic accepts_bytes(input state_t s);
        return (s != S_RUN) && (s != S_ERR);
    endfunction

endpackage

// File: rtl/imem_loader_byte_pair_packer.sv
// Latches the high byte of a word, then emits the assembled 16-bit word
// with a one-cycle valid pulse the cycle after the low byte arrives.
module byte_pair_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        hi_load,
    input  logic        lo_load,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic        word_vld
);

    logic [7:0]  hi_q,   hi_d;
    logic [15:0] word_q, word_d;
    logic        vld_q,  vld_d;

    // Next-value logic: the word register holds its last value between writes.
    always_comb begin
        hi_d   = hi_q;
        word_d = word_q;
        vld_d  = 1'b0;
        if (clear) begin
            hi_d = 8'h00;
        end else if (hi_load) begin
            hi_d = byte_in;
        end else if (lo_load) begin
            word_d = {hi_q, byte_in};
            vld_d  = 1'b1;
        end
    end

    // Registers with async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= 8'h00;
            word_q <= 16'h0000;
            vld_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign word     = word_q;
    assign word_vld = vld_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a counted, checksummed byte
// frame, writes the words into imem and holds the core in reset until the
// checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    // Largest legal word count (memory depth), widened so 2^ADDR_W fits.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                core_rst_q, core_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                xfer;
    logic                hi_load, lo_load;
    logic [15:0]         n_full;
    logic [15:0]         pk_word;
    logic                pk_vld;

    // Ready is a pure state decode, gated low while reset is held.
    assign rx_ready = rst & accepts_bytes(state_q);
    // restart wins over a same-cycle byte, which is simply dropped.
    assign xfer     = rx_valid & rx_ready & ~restart;

    // Frame parser next-state, counters and registered status outputs.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        csum_d  = csum_q;
        words_d = words_q;
        addr_d  = addr_q;
        hi_load = 1'b0;
        lo_load = 1'b0;
        n_full  = {n_q[15:8], rx_data};
        if (restart) begin
            state_d = S_HDR_HI;
            n_d     = 16'h0000;
            csum_d  = '0;
            words_d = '0;
        end else if (xfer) begin
            case (state_q)
                S_HDR_HI: begin
                    n_d[15:8] = rx_data;
                    state_d   = S_HDR_LO;
                end
                S_HDR_LO: begin
                    n_d[7:0] = rx_data;
                    if ({1'b0, n_full} > MAX_WORDS) state_d = S_ERR;
                    else if (n_full == 16'h0000)    state_d = S_CHECK;
                    else                            state_d = S_DATA_HI;
                end
                S_DATA_HI: begin
                    hi_load = 1'b1;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    // Address is the pre-increment count; the write lands next cycle.
                    lo_load = 1'b1;
                    addr_d  = words_q[ADDR_W-1:0];
                    words_d = words_q + 1'b1;
                    csum_d  = csum_q ^ rx_data;
                    if (32'(words_q) + 32'd1 == 32'(n_q)) state_d = S_CHECK;
                    else                                  state_d = S_DATA_HI;
                end
                S_CHECK: begin
                    state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
                end
                default: state_d = state_q;
            endcase
        end
        core_rst_d = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
        err_d      = (state_d == S_ERR);
    end

    // Single FSM register bank with async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_HDR_HI;
            n_q        <= 16'h0000;
            csum_q     <= '0;
            words_q    <= '0;
            addr_q     <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            csum_q     <= csum_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    byte_pair_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (restart),
        .hi_load  (hi_load),
        .lo_load  (lo_load),
        .byte_in  (rx_data),
        .word     (pk_word),
        .word_vld (pk_vld)
    );

    assign imem_we      = pk_vld;
    assign imem_addr    = addr_q;
    assign imem_wdata   = DATA_W'(pk_word);
    assign core_rst     = core_rst_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench: a byte-index frame model predicts every
// output each cycle; literal checks pin the key scenarios.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid, restart;
    logic [7:0]        rx_data;
    logic              rx_ready, imem_we, core_rst, load_done, load_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
        .clk(clk), .rst(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .restart(restart), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
        .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (byte index within frame) ----------
    int          m_k, m_n, m_words;
    logic [7:0]  m_csum, m_hi;
    bit          m_done, m_err, m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_n = 0; m_words = 0; m_csum = 0; m_hi = 0;
            m_done = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 0;
        end else begin
            bit rdy;
            rdy  = !m_done && !m_err;
            m_we = 0;
            if (restart) begin
                m_k = 0; m_n = 0; m_words = 0; m_csum = 0; m_done = 0; m_err = 0;
            end else if (rx_valid && rdy) begin
                if (m_k == 0) begin
                    m_n = int'(rx_data) * 256;
                    m_k = 1;
                end else if (m_k == 1) begin
                    m_n = m_n + int'(rx_data);
                    m_k = 2;
                    if (m_n > (1 << ADDR_W)) m_err = 1;
                end else if (m_k < 2 + 2 * m_n) begin
                    m_csum = m_csum ^ rx_data;
                    if (((m_k - 2) % 2) == 0) m_hi = rx_data;
                    else begin
                        m_we    = 1;
                        m_addr  = m_words[7:0];
                        m_data  = {m_hi, rx_data};
                        m_words = m_words + 1;
                    end
                    m_k = m_k + 1;
                end else begin
                    if (rx_data == m_csum) m_done = 1;
                    else                   m_err  = 1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("rx_ready",     {31'b0, rx_ready},  {31'b0, rst_n && !m_done && !m_err});
        chk("imem_we",      {31'b0, imem_we},   {31'b0, m_we});
        chk("imem_addr",    32'(imem_addr),     32'(m_addr));
        chk("imem_wdata",   32'(imem_wdata),    32'(m_data));
        chk("core_rst",     {31'b0, core_rst},  {31'b0, !m_done});
        chk("load_done",    {31'b0, load_done}, {31'b0, m_done});
        chk("load_err",     {31'b0, load_err},  {31'b0, m_err});
        chk("words_loaded", 32'(words_loaded),  32'(m_words));
    end

    // Record what the DUT actually writes, for literal end-of-frame checks.
    logic [15:0] dut_mem [0:255];
    int          wr_cnt = 0;
    always @(negedge clk) if (imem_we) begin
        dut_mem[imem_addr] = imem_wdata;
        wr_cnt = wr_cnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    logic [15:0] wbuf [0:255];
    logic [7:0]  fq [$];

    task automatic build(input int n, input logic [15:0] hdr, input logic [7:0] cs_xor);
        logic [7:0] cs;
        cs = 8'h00;
        fq.delete();
        fq.push_back(hdr[15:8]);
        fq.push_back(hdr[7:0]);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = wbuf[i];
            fq.push_back(w[15:8]);
            fq.push_back(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        fq.push_back(cs ^ cs_xor);
    endtask

    // Starts and ends aligned to a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap, t;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            errors++;
            $display("FAIL handshake_timeout: rx_ready stayed %0b, required 1", rx_ready);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_range(input int lo, input int hi, input int gap_max);
        for (int i = lo; i < hi; i++) send_byte(fq[i], gap_max);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic nominal_words();
        wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD; wbuf[2] = 16'h0F0F;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w0, t0;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; restart = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("reset_core_rst", {31'b0, core_rst}, 32'd1);
        chk("reset_addr",     32'(imem_addr),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame, back-to-back bytes; data phase takes 6 cycles.
        nominal_words();
        build(3, 16'd3, 8'h00);
        chk("model_csum", 32'(fq[8]), 32'h40);
        w0 = wr_cnt;
        send_range(0, 2, 0);
        t0 = cyc;
        send_range(2, 8, 0);
        chk("data_phase_cycles", 32'(cyc - t0), 32'd6);
        send_range(8, 9, 0);
        @(negedge clk);
        chk("nom_writes", 32'(wr_cnt - w0), 32'd3);
        chk("nom_mem0", 32'(dut_mem[0]), 32'h1234);
        chk("nom_mem1", 32'(dut_mem[1]), 32'hABCD);
        chk("nom_mem2", 32'(dut_mem[2]), 32'h0F0F);
        chk("nom_words", 32'(words_loaded), 32'd3);
        chk("nom_done", {31'b0, load_done}, 32'd1);
        chk("nom_core_rst", {31'b0, core_rst}, 32'd0);
        pulse_restart();
        chk("restart_core_rst", {31'b0, core_rst}, 32'd1);

        // Bad checksum.
        build(3, 16'd3, 8'h01);
        w0 = wr_cnt;
        send_range(0, 9, 2);
        @(negedge clk);
        chk("bad_err", {31'b0, load_err}, 32'd1);
        chk("bad_core_rst", {31'b0, core_rst}, 32'd1);
        chk("bad_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("bad_writes", 32'(wr_cnt - w0), 32'd3);
        pulse_restart();

        // Empty frame.
        build(0, 16'd0, 8'h00);
        w0 = wr_cnt;
        send_range(0, 3, 1);
        @(negedge clk);
        chk("empty_done", {31'b0, load_done}, 32'd1);
        chk("empty_words", 32'(words_loaded), 32'd0);
        chk("empty_writes", 32'(wr_cnt - w0), 32'd0);
        pulse_restart();

        // Oversize header.
        build(0, 16'h0101, 8'h00);
        w0 = wr_cnt;
        send_range(0, 2, 1);
        @(negedge clk);
        chk("over_err", {31'b0, load_err}, 32'd1);
        chk("over_writes", 32'(wr_cnt - w0), 32'd0);
        pulse_restart();

        // Restart during DATA_LO with a concurrent byte: byte dropped.
        nominal_words();
        build(3, 16'd3, 8'h00);
        send_range(0, 3, 0);
        w0 = wr_cnt;
        rx_valid = 1'b1; rx_data = 8'h34; restart = 1'b1;
        @(negedge clk);
        restart = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        chk("rs_words", 32'(words_loaded), 32'd0);
        chk("rs_rx_ready", {31'b0, rx_ready}, 32'd1);
        chk("rs_writes", 32'(wr_cnt - w0), 32'd0);
        send_range(0, 9, 3);
        @(negedge clk);
        chk("rs_reload_done", {31'b0, load_done}, 32'd1);
        chk("rs_reload_mem1", 32'(dut_mem[1]), 32'hABCD);
        pulse_restart();

        // Async reset mid-load.
        build(3, 16'd3, 8'h00);
        send_range(0, 5, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_words", 32'(words_loaded), 32'd0);
        chk("arst_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("arst_core_rst", {31'b0, core_rst}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-depth load.
        for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
        build(256, 16'd256, 8'h00);
        w0 = wr_cnt;
        send_range(0, fq.size(), 0);
        @(negedge clk);
        chk("full_words", 32'(words_loaded), 32'd256);
        chk("full_done", {31'b0, load_done}, 32'd1);
        chk("full_writes", 32'(wr_cnt - w0), 32'd256);
        chk("full_last", 32'(dut_mem[255]), 32'(wbuf[255]));
        pulse_restart();

        // Random frames, random gaps, occasional bad checksum.
        for (int it = 0; it < 12; it++) begin
            int  n;
            bit  bad;
            n   = int'($urandom_range(0, 10));
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            build(n, 16'(n), bad ? 8'h5A : 8'h00);
            send_range(0, fq.size(), int'($urandom_range(0, 3)));
            @(negedge clk);
            chk("rand_done", {31'b0, load_done}, {31'b0, !bad});
            chk("rand_err",  {31'b0, load_err},  {31'b0, bad});
            pulse_restart();
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
